// File: rtl/jump_charge_controller_pkg.sv
// jump_charge_controller_pkg: charge-scale constants and FSM encoding shared with the display stage
package jump_charge_controller_pkg;
  localparam int THRESHOLD_SHIFT = 55;
  typedef enum logic [1:0] {IDLE = 2'd0, CHARGE = 2'd1, COOLDOWN = 2'd2} state_t;
  function automatic int max_charge(input int seq_len);
    return THRESHOLD_SHIFT * seq_len;
  endfunction
endpackage

// File: rtl/fq_div.sv
// fq_div: one-cycle tick every DIV clock cycles
module fq_div #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/jump_charge_controller_btn_edge_sync.sv
// btn_edge_sync: 2-FF synchronizer for the raw button with rise/fall pulses
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_s,
  output logic rise,
  output logic fall
);
  logic meta, btn_s_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {meta, btn_s, btn_s_d} <= '0;
    else {meta, btn_s, btn_s_d} <= {btn, meta, btn_s};
  assign rise = btn_s & ~btn_s_d;
  assign fall = ~btn_s & btn_s_d;
endmodule

// File: rtl/jump_charge_controller.sv
// jump_charge_controller: turns the jump button into a saturating charge level and a release jump pulse
module jump_charge_controller
  import jump_charge_controller_pkg::*;
#(
  parameter int PHY_WIDTH      = 16,
  parameter int SEQ_LEN        = 20,
  parameter int CHARGE_STEP    = 5,
  parameter int TICK_DIV       = 100_000,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 btn_jump,
  input  logic                 on_ground,
  output logic [PHY_WIDTH-1:0] charge_bar,
  output logic                 charging,
  output logic                 jump_valid,
  output logic [PHY_WIDTH-1:0] jump_vel
);
  localparam int CW = COOLDOWN_TICKS > 0 ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [PHY_WIDTH:0] MAX_W = (PHY_WIDTH + 1)'(max_charge(SEQ_LEN));
  localparam logic [PHY_WIDTH:0] STEP_W = (PHY_WIDTH + 1)'(CHARGE_STEP);
  state_t state;
  logic [CW-1:0] cnt;
  logic btn_s, btn_rise, btn_fall, tick;
  logic [PHY_WIDTH:0] sum;
  logic [PHY_WIDTH-1:0] next_charge;
  btn_edge_sync u_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .btn  (btn_jump),
    .btn_s(btn_s),
    .rise (btn_rise),
    .fall (btn_fall)
  );
  fq_div #(.DIV(TICK_DIV)) u_div (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .tick (tick)
  );
  // extra bit keeps the add from wrapping before the clamp
  assign sum = {1'b0, charge_bar} + STEP_W;
  assign next_charge = sum > MAX_W ? MAX_W[PHY_WIDTH-1:0] : sum[PHY_WIDTH-1:0];
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state      <= IDLE;
      charge_bar <= '0;
      charging   <= 1'b0;
      jump_valid <= 1'b0;
      jump_vel   <= '0;
      cnt        <= '0;
    end else begin
      jump_valid <= 1'b0;
      case (state)
        IDLE:
          if (btn_rise && on_ground) begin
            state      <= CHARGE;
            charge_bar <= PHY_WIDTH'(1);
            charging   <= 1'b1;
          end
        CHARGE:
          if (!on_ground) begin
            state      <= IDLE;
            charge_bar <= '0;
            charging   <= 1'b0;
          end else if (btn_fall) begin
            state      <= COOLDOWN;
            jump_vel   <= charge_bar;
            jump_valid <= 1'b1;
            charge_bar <= '0;
            charging   <= 1'b0;
            cnt        <= CW'(COOLDOWN_TICKS);
          end else if (tick) charge_bar <= next_charge;
        COOLDOWN:
          if (cnt == '0 && !btn_s) state <= IDLE;
          else if (tick && cnt != '0) cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jump_charge_controller.sv
// tb_jump_charge_controller: directed scenarios with a scoreboard of expected charge changes and jumps
module tb_jump_charge_controller;
  logic sys_clk = 1'b0, sys_rst_n = 1'b1, btn_jump = 1'b0, on_ground = 1'b1;
  logic [15:0] charge_bar, jump_vel;
  logic charging, jump_valid;
  int checks = 0, errors = 0;
  int exp_charge[$], exp_vel[$];
  logic [15:0] prev = '0;

  jump_charge_controller #(.TICK_DIV(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .btn_jump  (btn_jump),
    .on_ground (on_ground),
    .charge_bar(charge_bar),
    .charging  (charging),
    .jump_valid(jump_valid),
    .jump_vel  (jump_vel)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // every change of charge_bar and every jump pulse must match the next queued expectation
  always @(negedge sys_clk) begin
    if (charge_bar !== prev) begin
      chk("charge_change_expected", exp_charge.size() > 0, 1);
      if (exp_charge.size() > 0) chk("charge_value", charge_bar, exp_charge.pop_front());
      prev = charge_bar;
    end
    if (jump_valid === 1'b1) begin
      chk("jump_expected", exp_vel.size() > 0, 1);
      if (exp_vel.size() > 0) chk("jump_vel", jump_vel, exp_vel.pop_front());
      chk("charge_zero_on_jump", charge_bar, 0);
    end
  end

  task automatic push_ramp(input int last);
    for (int v = 1; v < last; v += 5) exp_charge.push_back(v);
    exp_charge.push_back(last);
  endtask

  task automatic wait_charge(input int v);
    int n = 0;
    while (charge_bar !== 16'(v) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("wait_charge", charge_bar, v);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    cycles(2);
    chk("rst_charge", charge_bar, 0);
    chk("rst_charging", charging, 0);
    chk("rst_jump_valid", jump_valid, 0);
    chk("rst_jump_vel", jump_vel, 0);
    sys_rst_n = 1'b1;
    cycles(2);
    // ten ticks then release between ticks
    push_ramp(51); exp_charge.push_back(0); exp_vel.push_back(51);
    btn_jump = 1'b1;
    wait_charge(51);
    chk("charging_high", charging, 1);
    btn_jump = 1'b0;
    cycles(3);
    chk("jv_pulse_51", jump_valid, 1);
    chk("charging_after_release", charging, 0);
    cycles(1);
    chk("jv_one_cycle", jump_valid, 0);
    chk("jump_vel_holds", jump_vel, 51);
    cycles(40);
    // release lands on the same edge as a tick
    push_ramp(26); exp_charge.push_back(0); exp_vel.push_back(26);
    btn_jump = 1'b1;
    wait_charge(26);
    cycles(1);
    btn_jump = 1'b0;
    cycles(3);
    chk("jv_pulse_26", jump_valid, 1);
    chk("jv_pre_increment", jump_vel, 26);
    cycles(40);
    // saturation at 1100
    push_ramp(1096); exp_charge.push_back(1100); exp_charge.push_back(0); exp_vel.push_back(1100);
    btn_jump = 1'b1;
    wait_charge(1100);
    cycles(60);
    chk("saturated_hold", charge_bar, 1100);
    btn_jump = 1'b0;
    cycles(3);
    chk("jv_pulse_1100", jump_valid, 1);
    chk("jv_1100", jump_vel, 1100);
    cycles(40);
    // leaving the ground aborts
    push_ramp(41); exp_charge.push_back(0);
    btn_jump = 1'b1;
    wait_charge(41);
    on_ground = 1'b0;
    cycles(1);
    chk("abort_charge", charge_bar, 0);
    chk("abort_charging", charging, 0);
    chk("abort_no_jump", jump_valid, 0);
    btn_jump = 1'b0;
    cycles(5);
    btn_jump = 1'b1;
    cycles(10);
    chk("air_press_idle", charging, 0);
    chk("air_press_charge", charge_bar, 0);
    chk("abort_vel_kept", jump_vel, 1100);
    btn_jump = 1'b0;
    cycles(5);
    on_ground = 1'b1;
    cycles(5);
    // held button through cooldown never retriggers
    push_ramp(11); exp_charge.push_back(0); exp_vel.push_back(11);
    btn_jump = 1'b1;
    wait_charge(11);
    btn_jump = 1'b0;
    cycles(3);
    chk("jv_pulse_11", jump_valid, 1);
    btn_jump = 1'b1;
    cycles(48);
    chk("cooldown_no_charge", charge_bar, 0);
    chk("cooldown_not_charging", charging, 0);
    btn_jump = 1'b0;
    cycles(10);
    exp_charge.push_back(1);
    btn_jump = 1'b1;
    cycles(2);
    chk("latency_not_early", charge_bar, 0);
    cycles(1);
    chk("latency_3", charge_bar, 1);
    // asynchronous reset mid-charge
    exp_charge.push_back(6); exp_charge.push_back(11); exp_charge.push_back(0);
    wait_charge(11);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    btn_jump = 1'b0;
    #1;
    chk("async_rst_charge", charge_bar, 0);
    chk("async_rst_charging", charging, 0);
    chk("async_rst_jv", jump_valid, 0);
    chk("async_rst_vel", jump_vel, 0);
    cycles(2);
    sys_rst_n = 1'b1;
    cycles(20);
    chk("no_jump_after_rst", jump_valid, 0);
    chk("charge_queue_drained", exp_charge.size(), 0);
    chk("vel_queue_drained", exp_vel.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
